memwb_stage: RTL and testbench
==============================

// Module: memwb_stage
// PURPOSE
//  Parametrised successor to the combinational wb selector: registered MEM/WB pipeline stage plus writeback.
//  Captures MEM-stage results on clk, aligns and extends sub-word loads, and selects the writeback source (imm/ALU, mem, link).
//  Drives regfile write port (datatoregfile, weregfile, waddr); supports stall/flush from hazard unit.
//  Sits between MEM stage and register file in the MIPS pipeline.
// PARAMETERS
//  DATA_W      32  datapath width (multiple of 16, >=32)
//  REG_ADDR_W  5   register address width
//  CNT_W       32  retire counter width (used only with MEMWB_RETIRE_CNT_EN)
// PORTS
//  clk            in   1           clock; all state updates on rising edge
//  rst_n          in   1           synchronous reset, active-low
//  stall          in   1           hold stage register contents
//  flush          in   1           insert bubble (valid<=0) on next edge
//  in_valid       in   1           MEM-stage instruction valid
//  in_we          in   1           instruction writes regfile
//  in_wb_sel      in   2           0=imm/ALU, 1=mem, 2=link (pc_link), 3=reserved (treated as 0)
//  in_ld_size     in   2           0=word, 1=half, 2=byte, 3=reserved (treated as word)
//  in_ld_signed   in   1           sign-extend sub-word load
//  in_byte_off    in   2           address[1:0] of load
//  in_waddr       in   REG_ADDR_W  destination register
//  datafrommem    in   DATA_W      raw memory read word
//  datafromimm    in   DATA_W      ALU/immediate result
//  pc_link        in   DATA_W      return address for link instructions
//  datatoregfile  out  DATA_W      writeback data
//  weregfile      out  1           regfile write enable
//  waddr          out  REG_ADDR_W  regfile write address
//  wb_valid       out  1           stage holds a valid instruction
//  retire_count   out  CNT_W       retired-instruction count (feature only)
// BEHAVIOUR
//  - Latency 1: inputs sampled at edge N appear on outputs after edge N; outputs are combinational from stage regs.
//  - Reset (rst_n=0 at edge): all stage regs 0 -> wb_valid=0, weregfile=0, waddr=0, datatoregfile=0, retire_count=0.
//  - Reset overrides stall/flush; reset mid-operation discards held instruction.
//  - Priority per edge: rst_n=0 > flush > stall > load. flush&stall together -> bubble.
//  - stall=1 (no flush): all stage regs hold; outputs unchanged; weregfile stays as held (regfile rewrite of same value is benign).
//  - Bubble: valid=0, we=0; other fields don't-care but held at 0.
//  - weregfile = valid & we & (waddr != 0); writes to r0 always suppressed.
//  - Load align (little-endian lanes): byte lane = byte_off; half lane = byte_off[1] (byte_off[0] ignored, no trap).
//    Sub-word result zero- or sign-extended to DATA_W per ld_signed; word passes through unchanged.
//  - Data select: sel 1 -> aligned mem data; sel 2 -> pc_link; sel 0/3 -> datafromimm.
//  - wb_valid = valid register.
// CONFIGURATION
//  - MEMWB_RETIRE_CNT_EN defined: retire_count increments by 1 on each edge where stage reg loads a new valid
//    instruction (no stall, no flush, in_valid=1); wraps modulo 2^CNT_W; cleared by reset only.
//  - Undefined: counter not built; retire_count tied to 0.
// STRUCTURE
//  - Package memwb_pkg: WB_SEL_IMM/MEM/LINK, LD_SIZE_WORD/HALF/BYTE localparams; shared with decode and MEM stage.
//  - Sub-module load_align (combinational): datafrommem, ld_size, ld_signed, byte_off -> aligned DATA_W word.
//  - Top holds stage regs, select mux, we gating, optional counter.
// TESTING
//  - Reset: rst_n=0 one edge with in_valid=1 -> all outputs 0, retire_count=0.
//  - Select: imm=1, mem=0, link=0x40, we=1, waddr=3; sel 0/1/2 over 3 edges -> data 1, 0, 0x40; weregfile=1.
//  - Loads: mem=0x80FF7F01; byte off=2 signed -> 0xFFFFFFFF; off=1 unsigned -> 0x0000007F; half off=2 signed -> 0xFFFF80FF.
//  - r0 guard: we=1, waddr=0 -> weregfile=0, wb_valid=1.
//  - Hazards: stall 2 cycles -> outputs frozen; flush&stall -> wb_valid=0, weregfile=0 next edge.
//  - Counter (MEMWB_RETIRE_CNT_EN): 5 valid loads, 1 stall, 1 flush -> retire_count=5; CNT_W=3 with 9 loads -> 1.

Source files
------------

// File: rtl/memwb_pkg.sv
// rtl/memwb_pkg.sv - writeback select and load size encodings shared by decode, MEM and MEM/WB stages
package memwb_pkg;

    localparam logic [1:0] WB_SEL_IMM  = 2'd0;
    localparam logic [1:0] WB_SEL_MEM  = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;

    localparam logic [1:0] LD_SIZE_WORD = 2'd0;
    localparam logic [1:0] LD_SIZE_HALF = 2'd1;
    localparam logic [1:0] LD_SIZE_BYTE = 2'd2;

endpackage

// File: rtl/memwb_stage_load_align.sv
// rtl/memwb_stage_load_align.sv - little-endian sub-word load lane select and zero/sign extension
module load_align
    import memwb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] datafrommem,
    input  logic [1:0]        ld_size,
    input  logic              ld_signed,
    input  logic [1:0]        byte_off,
    output logic [DATA_W-1:0] aligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Half lane ignores byte_off[0]: misaligned halves are silently rounded down.
    assign byte_lane = datafrommem[{byte_off, 3'b000} +: 8];
    assign half_lane = datafrommem[{byte_off[1], 4'b0000} +: 16];

    always_comb begin
        aligned = datafrommem;
        case (ld_size)
            LD_SIZE_BYTE: aligned = {{(DATA_W-8){ld_signed & byte_lane[7]}}, byte_lane};
            LD_SIZE_HALF: aligned = {{(DATA_W-16){ld_signed & half_lane[15]}}, half_lane};
            default:      aligned = datafrommem;
        endcase
    end

endmodule

// File: rtl/memwb_stage.sv
// rtl/memwb_stage.sv - registered MEM/WB stage with writeback select; MEMWB_RETIRE_CNT_EN adds retire counter
module memwb_stage
    import memwb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  in_valid,
    input  logic                  in_we,
    input  logic [1:0]            in_wb_sel,
    input  logic [1:0]            in_ld_size,
    input  logic                  in_ld_signed,
    input  logic [1:0]            in_byte_off,
    input  logic [REG_ADDR_W-1:0] in_waddr,
    input  logic [DATA_W-1:0]     datafrommem,
    input  logic [DATA_W-1:0]     datafromimm,
    input  logic [DATA_W-1:0]     pc_link,
    output logic [DATA_W-1:0]     datatoregfile,
    output logic                  weregfile,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic                  wb_valid,
    output logic [CNT_W-1:0]      retire_count
);

    logic [DATA_W-1:0]     mem_aligned;
    logic [DATA_W-1:0]     wb_data;
    logic                  valid_q;
    logic                  we_q;
    logic [REG_ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0]     data_q;

    load_align #(.DATA_W(DATA_W)) u_load_align (
        .datafrommem (datafrommem),
        .ld_size     (in_ld_size),
        .ld_signed   (in_ld_signed),
        .byte_off    (in_byte_off),
        .aligned     (mem_aligned)
    );

    // Source is resolved before the register so the stage holds a single data word.
    always_comb begin
        wb_data = datafromimm;
        case (in_wb_sel)
            WB_SEL_MEM:  wb_data = mem_aligned;
            WB_SEL_LINK: wb_data = pc_link;
            default:     wb_data = datafromimm;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            data_q  <= '0;
        end else if (!stall) begin
            valid_q <= in_valid;
            we_q    <= in_we;
            waddr_q <= in_waddr;
            data_q  <= wb_data;
        end
    end

    assign datatoregfile = data_q;
    assign waddr         = waddr_q;
    assign wb_valid      = valid_q;
    assign weregfile     = valid_q & we_q & (waddr_q != '0);

`ifdef MEMWB_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            retire_q <= '0;
        end else if (!flush && !stall && in_valid) begin
            retire_q <= retire_q + CNT_W'(1);
        end
    end

    assign retire_count = retire_q;
`else
    assign retire_count = '0;
`endif

endmodule

// File: tb/tb_memwb_stage.sv
// tb/tb_memwb_stage.sv - scoreboard bench for memwb_stage (retire count checked when MEMWB_RETIRE_CNT_EN is defined)
module tb_memwb_stage;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, in_valid, in_we, in_ld_signed;
    logic [1:0]  in_wb_sel, in_ld_size, in_byte_off;
    logic [4:0]  in_waddr;
    logic [31:0] datafrommem, datafromimm, pc_link;
    logic [31:0] datatoregfile;
    logic        weregfile, wb_valid;
    logic [4:0]  waddr;
    logic [31:0] retire_count;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t model;
    int   checks = 0;
    int   errors = 0;

    memwb_stage #(.DATA_W(32), .REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_we(in_we), .in_wb_sel(in_wb_sel),
        .in_ld_size(in_ld_size), .in_ld_signed(in_ld_signed),
        .in_byte_off(in_byte_off), .in_waddr(in_waddr),
        .datafrommem(datafrommem), .datafromimm(datafromimm), .pc_link(pc_link),
        .datatoregfile(datatoregfile), .weregfile(weregfile), .waddr(waddr),
        .wb_valid(wb_valid), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_data();
        logic [31:0] sh;
        case (in_wb_sel)
            2'd1: begin
                if (in_ld_size == 2'd2) begin
                    sh = datafrommem >> (8 * in_byte_off);
                    return in_ld_signed ? 32'($signed(sh[7:0])) : {24'd0, sh[7:0]};
                end else if (in_ld_size == 2'd1) begin
                    sh = datafrommem >> (16 * in_byte_off[1]);
                    return in_ld_signed ? 32'($signed(sh[15:0])) : {16'd0, sh[15:0]};
                end
                return datafrommem;
            end
            2'd2:    return pc_link;
            default: return datafromimm;
        endcase
    endfunction

    // Predict the stage state after the coming edge; use_dat forces a hand-derived data value.
    task automatic push_expect(input logic use_dat, input logic [31:0] dat);
        exp_t n;
        n = model;
        if (!rst_n) begin
            n = '0;
        end else if (flush) begin
            n.valid = 1'b0; n.we = 1'b0; n.addr = '0; n.data = '0;
        end else if (!stall) begin
            n.valid = in_valid;
            n.we    = in_we;
            n.addr  = in_waddr;
            n.data  = use_dat ? dat : model_data();
`ifdef MEMWB_RETIRE_CNT_EN
            if (in_valid) n.cnt = model.cnt + 32'd1;
`endif
        end
        model = n;
        exp_q.push_back(n);
    endtask

    task automatic step(input string tag, input logic use_dat, input logic [31:0] dat);
        exp_t e;
        push_expect(use_dat, dat);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, ".queue_empty"}, 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, ".wb_valid"}, 64'(wb_valid), 64'(e.valid));
            check({tag, ".weregfile"}, 64'(weregfile), 64'(e.valid & e.we & (e.addr != 5'd0)));
            check({tag, ".waddr"}, 64'(waddr), 64'(e.addr));
            check({tag, ".data"}, 64'(datatoregfile), 64'(e.data));
            check({tag, ".retire"}, 64'(retire_count), 64'(e.cnt));
        end
    endtask

    task automatic set_op(input logic [1:0] sel, input logic [1:0] size, input logic sgn, input logic [1:0] off);
        in_wb_sel = sel; in_ld_size = size; in_ld_signed = sgn; in_byte_off = off;
    endtask

    initial begin
        model = '0;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        in_valid = 1'b1; in_we = 1'b1; in_waddr = 5'd7;
        set_op(2'd0, 2'd0, 1'b0, 2'd0);
        datafrommem = 32'h1234_5678; datafromimm = 32'hDEAD_BEEF; pc_link = 32'h4;
        #1;
        step("reset", 1'b1, 32'h0);
        rst_n = 1'b1;

        datafromimm = 32'h1; datafrommem = 32'h0; pc_link = 32'h40; in_waddr = 5'd3;
        set_op(2'd0, 2'd0, 1'b0, 2'd0); step("sel_imm",  1'b1, 32'h1);
        set_op(2'd1, 2'd0, 1'b0, 2'd0); step("sel_mem",  1'b1, 32'h0);
        set_op(2'd2, 2'd0, 1'b0, 2'd0); step("sel_link", 1'b1, 32'h40);
        set_op(2'd3, 2'd0, 1'b0, 2'd0); step("sel_rsvd", 1'b1, 32'h1);

        datafrommem = 32'h80FF_7F01;
        set_op(2'd1, 2'd2, 1'b1, 2'd2); step("ld_b_s2",  1'b1, 32'hFFFF_FFFF);
        set_op(2'd1, 2'd2, 1'b0, 2'd1); step("ld_b_u1",  1'b1, 32'h0000_007F);
        set_op(2'd1, 2'd1, 1'b1, 2'd2); step("ld_h_s2",  1'b1, 32'hFFFF_80FF);
        set_op(2'd1, 2'd1, 1'b1, 2'd1); step("ld_h_s1",  1'b1, 32'h0000_7F01);
        set_op(2'd1, 2'd3, 1'b1, 2'd3); step("ld_rsvd",  1'b1, 32'h80FF_7F01);

        in_waddr = 5'd0; set_op(2'd0, 2'd0, 1'b0, 2'd0);
        step("r0_guard", 1'b1, 32'h1);

        in_waddr = 5'd9; datafromimm = 32'hA5A5_0001; step("pre_stall", 1'b1, 32'hA5A5_0001);
        stall = 1'b1; datafromimm = 32'h0BAD_0BAD; in_waddr = 5'd12;
        step("stall1", 1'b0, 32'h0);
        step("stall2", 1'b0, 32'h0);
        flush = 1'b1;
        step("flush_stall", 1'b0, 32'h0);
        stall = 1'b0;
        step("flush", 1'b0, 32'h0);
        flush = 1'b0;
        step("post_flush", 1'b1, 32'h0BAD_0BAD);

        for (int i = 0; i < 60; i++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            in_valid = $urandom_range(0, 1) == 1;
            in_we = $urandom_range(0, 1) == 1;
            in_waddr = 5'($urandom_range(0, 31));
            set_op(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
            datafrommem = $urandom; datafromimm = $urandom; pc_link = $urandom;
            step("rand", 1'b0, 32'h0);
        end

        stall = 1'b1; flush = 1'b0; in_valid = 1'b1; rst_n = 1'b0;
        step("mid_reset", 1'b1, 32'h0);
        rst_n = 1'b1; stall = 1'b0;
        step("after_reset", 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
